mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DM_BYTES, default 4096, meaning data-memory size in bytes; legal byte addresses are 0..DM_BYTES-1.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request from EX/MEM register is present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 SHALL have ports req_addr, req_wdata, req_pc  input  32 each  byte address, store data (low bits used for SH/SB), instruction PC.
REQ-008 SHALL have port req_rd  input  5  load destination register.
REQ-009 SHALL have ports dm_we  output  1 and dm_addr, dm_wdata, dm_pc  output  32 each  word-write drive into data memory (dm_addr[1:0] = 0).
REQ-010 SHALL have port dm_rdata  input  32  combinational word read of dm_addr.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_data  output  32, rsp_rd  output  5, rsp_pc  output  32, rsp_exc  output  2 (00 none, 01 load address error, 10 store address error).

Function
REQ-012 SHALL use FSM states IDLE, ACCESS, MERGE; req_ready = 1 only in IDLE.
REQ-013 SHALL, in IDLE with req_valid, capture op/addr/wdata/pc/rd into internal registers.
REQ-014 SHALL flag an address error on capture when: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0; or addr >= DM_BYTES.
REQ-015 SHALL, on an address error, stay in IDLE, never assert dm_we, and pulse rsp_valid next cycle with rsp_exc (01 loads, 10 stores), rsp_data=0, rsp_rd=0.
REQ-016 SHALL otherwise go to ACCESS, driving dm_addr = {addr[31:2],2'b00} and dm_pc = captured pc in ACCESS and MERGE.
REQ-017 SHALL, for loads in ACCESS, register the extended lane of dm_rdata into rsp_data, pulse rsp_valid next cycle with rsp_rd = captured rd, return to IDLE.
REQ-018 SHALL use little-endian lanes: byte k = bits [8k+7:8k] for addr[1:0]=k; half h = bits [16h+15:16h] for addr[1]=h; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-019 SHALL, for SW in ACCESS, assert dm_we with dm_wdata = wdata for exactly one cycle, then pulse rsp_valid (rsp_data=0, rsp_rd=0), return to IDLE.
REQ-020 SHALL, for SH/SB in ACCESS, latch dm_rdata with dm_we=0 and go to MERGE.
REQ-021 SHALL, in MERGE, assert dm_we for one cycle with dm_wdata = latched word with only the addressed lane replaced by wdata[7:0]/wdata[15:0], then pulse rsp_valid, return to IDLE.
REQ-022 SHALL give latency accept->rsp_valid: 1 cycle address error, 2 cycles loads/SW, 3 cycles SH/SB.
REQ-023 SHALL hold rsp_valid high exactly one cycle per accepted request; rsp_pc = captured pc; rsp_* hold last value when rsp_valid=0.
REQ-024 SHALL ignore req_* while req_ready=0 (upstream holds request).
REQ-025 SHALL keep dm_we=0 in IDLE and in every cycle reset is high.

Reset
REQ-026 SHALL, on reset, force IDLE and clear all outputs and internal registers to 0, aborting any in-flight access with no write and no response.
REQ-027 SHALL give reset priority over a simultaneous req_valid; the request is not accepted.

Structure
REQ-028 SHALL place op encodings, rsp_exc codes and FSM state encodings in shared package mem_pkg.
REQ-029 SHALL implement lane extraction/extension as combinational sub-module load_ext (inputs op, addr[1:0], word; output 32-bit data).

Verification
REQ-030 SHALL cover: mem[0x10]=0x8899AABB; LB 0x11 -> rsp_data 0xFFFFFFAA at accept+2; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899.
REQ-031 SHALL cover: mem[0x20]=0x11223344; SB 0x23 wdata 0x000000EE -> one dm_we at accept+2, mem[0x20]=0xEE223344, rsp_valid at accept+3.
REQ-032 SHALL cover: SW 0x02 -> no dm_we, rsp_exc=10 at accept+1; LH 0x01 -> rsp_exc=01; LW 0x1000 (DM_BYTES=4096) -> rsp_exc=01.
REQ-033 SHALL cover: reset asserted in MERGE of SH 0x40 -> dm_we=0, no rsp_valid, mem[0x40] unchanged, req_ready=1 after reset.
REQ-034 SHALL cover: back-to-back SW 0x0 (0x5), LW 0x0 with req_valid held -> req_ready low in ACCESS, LW returns 0x00000005, exactly two rsp_valid pulses.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: op codes, exception codes,
// FSM states and the store-merge helper.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        EXC_NONE  = 2'b00,
        EXC_LOAD  = 2'b01,
        EXC_STORE = 2'b10
    } mem_exc_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2
    } mau_state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic addr_misaligned(input mem_op_e op, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = a[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Replace only the addressed byte/half of a word read back from memory.
    function automatic logic [31:0] merge_lane(input mem_op_e op, input logic [1:0] a,
                                               input logic [31:0] word, input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        if (op == OP_SB)
            r[{a, 3'b000} +: 8] = wdata[7:0];
        else if (op == OP_SH)
            r[{a[1], 4'b0000} +: 16] = wdata[15:0];
        return r;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte/half of a memory word and sign/zero extends it.
module load_ext
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = word[{addr[1], 4'b0000} +: 16];
        data     = word;
        case (mem_op_e'(op))
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h000000, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word-wide data memory port, read-modify-write for
// sub-word stores, one registered response per accepted request.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic [4:0]  req_rd,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_pc,
    output logic [1:0]  rsp_exc
);

    localparam logic [32:0] DM_LIMIT = 33'(DM_BYTES);

    mau_state_e  state_q, state_d;
    mem_op_e     op_q;
    logic [31:0] addr_q, wdata_q, pc_q, word_q;
    logic [4:0]  rd_q;
    logic [31:0] ext_data;
    mem_op_e     req_op_e;
    logic        req_err;

    assign req_op_e = mem_op_e'(req_op);
    assign req_err  = addr_misaligned(req_op_e, req_addr[1:0]) || ({1'b0, req_addr} >= DM_LIMIT);

    load_ext u_load_ext (
        .op   (op_q),
        .addr (addr_q[1:0]),
        .word (dm_rdata),
        .data (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // dm_we is gated by reset so an aborted merge never reaches memory.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_pc     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !req_err) state_d = ACCESS;
            end
            ACCESS: begin
                dm_addr = {addr_q[31:2], 2'b00};
                dm_pc   = pc_q;
                if (op_q == OP_SW) begin
                    dm_we    = !reset;
                    dm_wdata = wdata_q;
                end
                state_d = (op_q == OP_SH || op_q == OP_SB) ? MERGE : IDLE;
            end
            MERGE: begin
                dm_addr  = {addr_q[31:2], 2'b00};
                dm_pc    = pc_q;
                dm_we    = !reset;
                dm_wdata = merge_lane(op_q, addr_q[1:0], word_q, wdata_q);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_LW;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            word_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_pc    <= '0;
            rsp_exc   <= EXC_NONE;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op_e;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        rd_q    <= req_rd;
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_rd    <= '0;
                            rsp_pc    <= req_pc;
                            rsp_exc   <= is_store(req_op_e) ? EXC_STORE : EXC_LOAD;
                        end
                    end
                end
                ACCESS: begin
                    if (!is_store(op_q)) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= ext_data;
                        rsp_rd    <= rd_q;
                        rsp_pc    <= pc_q;
                        rsp_exc   <= EXC_NONE;
                    end else if (op_q == OP_SW) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_rd    <= '0;
                        rsp_pc    <= pc_q;
                        rsp_exc   <= EXC_NONE;
                    end else begin
                        word_q <= dm_rdata;
                    end
                end
                MERGE: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_rd    <= '0;
                    rsp_pc    <= pc_q;
                    rsp_exc   <= EXC_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single requests plus
// hand-written reset-abort, reset-priority and back-to-back sequences.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic [4:0]  req_rd;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data, rsp_pc;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_exc;

    mem_access_unit #(.DM_BYTES(4096)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .req_rd    (req_rd),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_pc     (dm_pc),
        .dm_rdata  (dm_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd),
        .rsp_pc    (rsp_pc),
        .rsp_exc   (rsp_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        preload;
    int          we_total;
    int          rsp_total;

    assign dm_rdata = mem[dm_addr[11:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[4]  <= 32'h8899AABB;
            mem[8]  <= 32'h11223344;
            mem[16] <= 32'hCAFEF00D;
        end else if (dm_we) begin
            mem[dm_addr[11:2]] <= dm_wdata;
        end
        if (dm_we) we_total <= we_total + 1;
        if (rsp_valid) rsp_total <= rsp_total + 1;
    end

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_exc;
        int          exp_lat;
        int          exp_we_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        logic [4:0]  rd;
        logic [31:0] pc;
        int          lat, we_n, we_cyc;
        logic [31:0] got_data, got_pc;
        logic [4:0]  got_rd;
        logic [1:0]  got_exc;
        logic        load_ok;
        rd = 5'(idx + 1);
        pc = 32'h400 + 32'(idx * 4);
        load_ok = (v.op <= 3'd4) && (v.exp_exc == 2'b00);
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
        req_wdata = v.wdata; req_pc = pc; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_n = 0; we_cyc = 0;
        got_data = '0; got_pc = '0; got_rd = '0; got_exc = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (dm_we) begin we_n++; we_cyc = k; end
            if (rsp_valid) begin
                lat = k; got_data = rsp_data; got_pc = rsp_pc;
                got_rd = rsp_rd; got_exc = rsp_exc;
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_data", idx), got_data, v.exp_data);
        check($sformatf("v%0d_exc", idx), {30'd0, got_exc}, {30'd0, v.exp_exc});
        check($sformatf("v%0d_rd", idx), {27'd0, got_rd}, load_ok ? {27'd0, rd} : 32'd0);
        check($sformatf("v%0d_pc", idx), got_pc, pc);
        check($sformatf("v%0d_we_count", idx), 32'(we_n), (v.exp_we_cyc != 0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_we_cycle", idx), 32'(we_cyc), 32'(v.exp_we_cyc));
        @(negedge clk);
        check($sformatf("v%0d_rsp_one_cycle", idx), {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int rsp0, we0;
        n_pass = 0; n_total = 0;
        we_total = 0; rsp_total = 0;
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; req_pc = '0; req_rd = '0;

        // loads on mem[0x10] = 0x8899AABB
        vecs.push_back('{OP_LB,  32'h11, 32'h0, 32'hFFFFFFAA, 2'b00, 2, 0});
        vecs.push_back('{OP_LBU, 32'h11, 32'h0, 32'h000000AA, 2'b00, 2, 0});
        vecs.push_back('{OP_LH,  32'h12, 32'h0, 32'hFFFF8899, 2'b00, 2, 0});
        vecs.push_back('{OP_LHU, 32'h12, 32'h0, 32'h00008899, 2'b00, 2, 0});
        vecs.push_back('{OP_LW,  32'h10, 32'h0, 32'h8899AABB, 2'b00, 2, 0});
        vecs.push_back('{OP_LB,  32'h13, 32'h0, 32'hFFFFFF88, 2'b00, 2, 0});
        vecs.push_back('{OP_LB,  32'h10, 32'h0, 32'hFFFFFFBB, 2'b00, 2, 0});
        vecs.push_back('{OP_LBU, 32'h12, 32'h0, 32'h00000099, 2'b00, 2, 0});
        vecs.push_back('{OP_LH,  32'h10, 32'h0, 32'hFFFFAABB, 2'b00, 2, 0});
        // sub-word stores on mem[0x20] = 0x11223344
        vecs.push_back('{OP_SB,  32'h23, 32'h000000EE, 32'h0, 2'b00, 3, 2});
        vecs.push_back('{OP_LW,  32'h20, 32'h0, 32'hEE223344, 2'b00, 2, 0});
        vecs.push_back('{OP_SH,  32'h20, 32'h1234ABCD, 32'h0, 2'b00, 3, 2});
        vecs.push_back('{OP_LW,  32'h20, 32'h0, 32'hEE22ABCD, 2'b00, 2, 0});
        vecs.push_back('{OP_SH,  32'h22, 32'h00007777, 32'h0, 2'b00, 3, 2});
        vecs.push_back('{OP_LH,  32'h22, 32'h0, 32'h00007777, 2'b00, 2, 0});
        vecs.push_back('{OP_SB,  32'h20, 32'hFFFFFF80, 32'h0, 2'b00, 3, 2});
        vecs.push_back('{OP_LW,  32'h20, 32'h0, 32'h7777AB80, 2'b00, 2, 0});
        vecs.push_back('{OP_LB,  32'h20, 32'h0, 32'hFFFFFF80, 2'b00, 2, 0});
        // address errors
        vecs.push_back('{OP_SW,  32'h02, 32'h12345678, 32'h0, 2'b10, 1, 0});
        vecs.push_back('{OP_LH,  32'h01, 32'h0, 32'h0, 2'b01, 1, 0});
        vecs.push_back('{OP_LW,  32'h1000, 32'h0, 32'h0, 2'b01, 1, 0});
        vecs.push_back('{OP_SB,  32'h1000, 32'h11, 32'h0, 2'b10, 1, 0});
        vecs.push_back('{OP_SH,  32'h03, 32'h11, 32'h0, 2'b10, 1, 0});
        vecs.push_back('{OP_LHU, 32'h11, 32'h0, 32'h0, 2'b01, 1, 0});
        vecs.push_back('{OP_LBU, 32'h2000, 32'h0, 32'h0, 2'b01, 1, 0});
        // word store and top-of-memory boundary
        vecs.push_back('{OP_SW,  32'h24, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1});
        vecs.push_back('{OP_LW,  32'h24, 32'h0, 32'hDEADBEEF, 2'b00, 2, 0});
        vecs.push_back('{OP_SB,  32'hFFF, 32'h0000005A, 32'h0, 2'b00, 3, 2});
        vecs.push_back('{OP_LBU, 32'hFFF, 32'h0, 32'h0000005A, 2'b00, 2, 0});
        vecs.push_back('{OP_LW,  32'hFFC, 32'h0, 32'h5A000000, 2'b00, 2, 0});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0; preload = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_dm_we", {31'd0, dm_we}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_dm_addr", dm_addr, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // reset during MERGE of SH 0x40 aborts the write and the response
        @(negedge clk);
        we0 = we_total; rsp0 = rsp_total;
        req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h40;
        req_wdata = 32'h00005555; req_pc = 32'h900; req_rd = 5'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_access_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_merge_we", {31'd0, dm_we}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_write", 32'(we_total - we0), 32'd0);
        check("abort_no_rsp", 32'(rsp_total - rsp0), 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_pc_cleared", rsp_pc, 32'd0);
        run_vec('{OP_LW, 32'h40, 32'h0, 32'hCAFEF00D, 2'b00, 2, 0}, 40);

        // reset wins over a simultaneous request
        @(negedge clk);
        rsp0 = rsp_total;
        reset = 1'b1; req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rstprio_ready", {31'd0, req_ready}, 32'd1);
        check("rstprio_we", {31'd0, dm_we}, 32'd0);
        repeat (2) @(negedge clk);
        check("rstprio_no_rsp", 32'(rsp_total - rsp0), 32'd0);
        run_vec('{OP_LW, 32'h10, 32'h0, 32'h8899AABB, 2'b00, 2, 0}, 41);

        // back-to-back SW 0x0 then LW 0x0 with req_valid held high
        @(negedge clk);
        rsp0 = rsp_total;
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0;
        req_wdata = 32'h5; req_pc = 32'hA00; req_rd = 5'd0;
        @(posedge clk);
        #1 req_op = OP_LW; req_wdata = 32'h0; req_pc = 32'hA04; req_rd = 5'd7;
        @(negedge clk);
        check("b2b_ready_access", {31'd0, req_ready}, 32'd0);
        check("b2b_sw_we", {31'd0, dm_we}, 32'd1);
        check("b2b_sw_wdata", dm_wdata, 32'h5);
        @(negedge clk);
        check("b2b_sw_rsp", {31'd0, rsp_valid}, 32'd1);
        check("b2b_sw_rsp_pc", rsp_pc, 32'hA00);
        check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_lw_ready_access", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_lw_rsp", {31'd0, rsp_valid}, 32'd1);
        check("b2b_lw_data", rsp_data, 32'h00000005);
        check("b2b_lw_rd", {27'd0, rsp_rd}, 32'd7);
        repeat (3) @(negedge clk);
        check("b2b_rsp_pulses", 32'(rsp_total - rsp0), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
